// File: rtl/lc2k_mem_requester.sv
// LC2K data-memory initiator: turns one CPU load/store command into a req/ack
// memory transaction with word-address bounds check, timeout and a done/err pulse.
module lc2k_mem_requester #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_start,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             addr_oob_c;

  // Any set bit above the implemented word-address range is out of bounds.
  assign addr_oob_c = |cpu_addr[DATA_W-1:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_start) begin
            cpu_busy  <= 1'b1;
            cnt       <= '0;
            mem_addr  <= cpu_addr[ADDR_W-1:0];
            mem_wdata <= cpu_wdata;
            if (addr_oob_c) begin
              // Rejected without ever touching the memory side.
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
              state    <= S_ERR;
            end else begin
              mem_req <= 1'b1;
              mem_we  <= cpu_we;
              state   <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // Ack on the last allowed cycle is checked first so it beats the timeout.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= 1'b1;
            cpu_err  <= 1'b0;
            if (!mem_we) begin
              cpu_rdata <= mem_rdata;
            end
            state <= S_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
            state    <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE, S_ERR: begin
          cpu_done <= 1'b0;
          cpu_err  <= 1'b0;
          cpu_busy <= 1'b0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc2k_mem_requester.sv
// Directed bench for lc2k_mem_requester: loads, stores, range errors, timeout,
// ignored inputs, back-to-back start and mid-transaction reset.
module tb_lc2k_mem_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_start;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int req_total = 0;
  int done_total = 0;
  int r0;
  int d0;

  lc2k_mem_requester #(.DATA_W(32), .ADDR_W(6), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_start (cpu_start),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_done  (cpu_done),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Running totals of cycles with mem_req high and cycles with cpu_done high.
  always @(posedge clk) begin
    if (mem_req === 1'b1) req_total++;
    if (cpu_done === 1'b1) done_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_start = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    #12;
    check("rst_busy",  32'(cpu_busy), 32'd0);
    check("rst_done",  32'(cpu_done), 32'd0);
    check("rst_req",   32'(mem_req),  32'd0);
    check("rst_rdata", cpu_rdata,     32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: load addr 9, ack after 3 request cycles, rdata 1
    r0 = req_total; d0 = done_total;
    cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9;
    tick();
    cpu_start = 1'b0;
    check("t1_req",  32'(mem_req),  32'd1);
    check("t1_we",   32'(mem_we),   32'd0);
    check("t1_addr", 32'(mem_addr), 32'd9);
    check("t1_busy", 32'(cpu_busy), 32'd1);
    tick();
    check("t1_req2", 32'(mem_req),  32'd1);
    tick();
    check("t1_req3", 32'(mem_req),  32'd1);
    mem_ack = 1'b1; mem_rdata = 32'd1;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hAAAA_AAAA;
    check("t1_reqlo", 32'(mem_req),  32'd0);
    check("t1_done",  32'(cpu_done), 32'd1);
    check("t1_err",   32'(cpu_err),  32'd0);
    check("t1_rdata", cpu_rdata,     32'd1);
    tick();
    check("t1_done_off", 32'(cpu_done), 32'd0);
    check("t1_busy_off", 32'(cpu_busy), 32'd0);
    check("t1_reqcyc",  32'(req_total - r0),  32'd3);
    check("t1_donecnt", 32'(done_total - d0), 32'd1);

    // 2: store addr 10 data DEADBEEF, ack in first request cycle
    cpu_start = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd10; cpu_wdata = 32'hDEAD_BEEF;
    tick();
    cpu_start = 1'b0;
    check("t2_req",   32'(mem_req),  32'd1);
    check("t2_we",    32'(mem_we),   32'd1);
    check("t2_addr",  32'(mem_addr), 32'd10);
    check("t2_wdata", mem_wdata,     32'hDEAD_BEEF);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    check("t2_done",  32'(cpu_done), 32'd1);
    check("t2_err",   32'(cpu_err),  32'd0);
    check("t2_we_lo", 32'(mem_we),   32'd0);
    check("t2_rdata", cpu_rdata,     32'd1);
    tick();

    // 3: out-of-range addresses never reach memory
    r0 = req_total; d0 = done_total;
    cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd64;
    tick();
    cpu_start = 1'b0;
    check("t3a_req",  32'(mem_req),  32'd0);
    check("t3a_done", 32'(cpu_done), 32'd1);
    check("t3a_err",  32'(cpu_err),  32'd1);
    tick();
    check("t3a_done_off", 32'(cpu_done), 32'd0);
    check("t3a_err_off",  32'(cpu_err),  32'd0);
    cpu_start = 1'b1; cpu_addr = 32'hFFFF_FFFF;
    tick();
    cpu_start = 1'b0;
    check("t3b_done", 32'(cpu_done), 32'd1);
    check("t3b_err",  32'(cpu_err),  32'd1);
    tick();
    check("t3_reqcyc",  32'(req_total - r0),  32'd0);
    check("t3_donecnt", 32'(done_total - d0), 32'd2);
    check("t3_rdata",   cpu_rdata,            32'd1);

    // 4a: no ack -> 16 request cycles then timeout error
    r0 = req_total;
    cpu_start = 1'b1; cpu_addr = 32'd5;
    tick();
    cpu_start = 1'b0;
    repeat (15) tick();
    check("t4a_req16", 32'(mem_req), 32'd1);
    tick();
    check("t4a_reqlo", 32'(mem_req),  32'd0);
    check("t4a_done",  32'(cpu_done), 32'd1);
    check("t4a_err",   32'(cpu_err),  32'd1);
    tick();
    check("t4a_reqcyc", 32'(req_total - r0), 32'd16);
    check("t4a_rdata",  cpu_rdata,           32'd1);

    // 4b: ack on the 16th cycle succeeds
    cpu_start = 1'b1; cpu_addr = 32'd6;
    tick();
    cpu_start = 1'b0;
    repeat (15) tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000_BEEF;
    tick();
    mem_ack = 1'b0;
    check("t4b_done",  32'(cpu_done), 32'd1);
    check("t4b_err",   32'(cpu_err),  32'd0);
    check("t4b_rdata", cpu_rdata,     32'h0000_BEEF);
    tick();

    // 5: start during REQ/DONE ignored, ack in IDLE ignored, start at M+2 accepted
    d0 = done_total;
    cpu_start = 1'b1; cpu_addr = 32'd3;
    tick();
    cpu_addr = 32'd4;
    tick();
    check("t5_addr_hold", 32'(mem_addr), 32'd3);
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    cpu_start = 1'b0; mem_ack = 1'b0;
    check("t5_done", 32'(cpu_done), 32'd1);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("t5_idle_ack_req",  32'(mem_req),  32'd0);
    check("t5_idle_ack_done", 32'(cpu_done), 32'd0);
    check("t5_idle_busy",     32'(cpu_busy), 32'd0);
    cpu_start = 1'b1; cpu_addr = 32'd7;
    tick();
    cpu_start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
    tick();
    mem_ack = 1'b0;
    check("t5_m_done", 32'(cpu_done), 32'd1);
    cpu_start = 1'b1; cpu_addr = 32'd8;
    tick();
    check("t5_m1_req",  32'(mem_req),  32'd0);
    check("t5_m1_busy", 32'(cpu_busy), 32'd0);
    tick();
    cpu_start = 1'b0;
    check("t5_m2_req",  32'(mem_req),  32'd1);
    check("t5_m2_addr", 32'(mem_addr), 32'd8);
    mem_ack = 1'b1; mem_rdata = 32'h88;
    tick();
    mem_ack = 1'b0;
    check("t5_m2_rdata", cpu_rdata, 32'h88);
    tick();
    check("t5_donecnt", 32'(done_total - d0), 32'd3);

    // 6: reset mid-REQ abandons the transaction
    d0 = done_total;
    cpu_start = 1'b1; cpu_addr = 32'd9;
    tick();
    cpu_start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_req",   32'(mem_req),  32'd0);
    check("t6_busy",  32'(cpu_busy), 32'd0);
    check("t6_addr",  32'(mem_addr), 32'd0);
    check("t6_rdata", cpu_rdata,     32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_nodone", 32'(done_total - d0), 32'd0);
    cpu_start = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9;
    tick();
    cpu_start = 1'b0;
    check("t6_req2", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'd1;
    tick();
    mem_ack = 1'b0;
    check("t6_done",  32'(cpu_done), 32'd1);
    check("t6_err",   32'(cpu_err),  32'd0);
    check("t6_rdata2", cpu_rdata,    32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
